// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
// Frame-level controller around a streaming FFT core: gates FFT_SIZE input
// samples into the core buffer, waits for the transform (bounded by TIMEOUT),
// drains the result with READ_OUTP and re-emits the bins with index/last
// markers, frame counter and sticky error flags.
// Optional build macro FFT_SEQ_PEAK_EN adds a per-frame |re|+|im| peak detector
// (peak_mag, peak_bin, peak_valid).
`timescale 1ns/1ps
module fft_frame_sequencer #(
    parameter int FFT_SIZE = 256,
    parameter int WIDTH    = 32,
    parameter int TIMEOUT  = 4096
) (
    input  logic                        CLK,
    input  logic                        NGRST,
    input  logic                        run,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [WIDTH-1:0]            s_re,
    input  logic [WIDTH-1:0]            s_im,
    output logic [WIDTH-1:0]            fft_datai_re,
    output logic [WIDTH-1:0]            fft_datai_im,
    output logic                        fft_datai_valid,
    input  logic                        fft_buf_ready,
    input  logic                        fft_outp_ready,
    output logic                        fft_read_outp,
    input  logic [WIDTH-1:0]            fft_datao_re,
    input  logic [WIDTH-1:0]            fft_datao_im,
    input  logic                        fft_datao_valid,
    output logic                        m_valid,
    output logic [WIDTH-1:0]            m_re,
    output logic [WIDTH-1:0]            m_im,
    output logic [$clog2(FFT_SIZE)-1:0] m_bin,
    output logic                        m_last,
    output logic                        frame_done,
    output logic [15:0]                 frame_cnt,
    output logic                        err_timeout,
    output logic                        err_overrun,
    input  logic                        err_clr
`ifdef FFT_SEQ_PEAK_EN
    ,
    output logic [WIDTH:0]              peak_mag,
    output logic [$clog2(FFT_SIZE)-1:0] peak_bin,
    output logic                        peak_valid
`endif
);

    localparam int BW = $clog2(FFT_SIZE);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BIN  = BW'(FFT_SIZE - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [BW-1:0] in_cnt_r;
    logic [BW-1:0] out_cnt_r;
    logic [TW-1:0] wait_cnt_r;
    logic          accept_s;
    logic          capture_s;
    logic          overrun_s;
    logic          timeout_s;
    logic          last_in_s;
    logic          last_out_s;

    // State register
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decision; run is only looked at from IDLE and DONE
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run) state_nx_s = ST_LOAD;
                else     state_nx_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (last_in_s) state_nx_s = ST_WAIT;
                else           state_nx_s = ST_LOAD;
            end
            ST_WAIT: begin
                if (fft_outp_ready) state_nx_s = ST_UNLOAD;
                else if (timeout_s) state_nx_s = ST_IDLE;
                else                state_nx_s = ST_WAIT;
            end
            ST_UNLOAD: begin
                if (last_out_s) state_nx_s = ST_DONE;
                else            state_nx_s = ST_UNLOAD;
            end
            ST_DONE: begin
                if (run) state_nx_s = ST_LOAD;
                else     state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Combinational handshake pass-through and event decode
    always_comb begin
        s_ready = 1'b0;
        if (state_r == ST_LOAD) s_ready = fft_buf_ready;
        else                    s_ready = 1'b0;
        accept_s        = s_valid & s_ready;
        fft_datai_valid = accept_s;
        fft_datai_re    = s_re;
        fft_datai_im    = s_im;
        capture_s  = fft_datao_valid & (state_r == ST_UNLOAD);
        overrun_s  = fft_datao_valid & (state_r != ST_UNLOAD);
        last_in_s  = accept_s & (in_cnt_r == LAST_BIN);
        last_out_s = capture_s & (out_cnt_r == LAST_BIN);
        timeout_s  = (state_r == ST_WAIT) & ~fft_outp_ready & (wait_cnt_r == WAIT_LAST);
    end

    // Sample, wait and bin counters; each clears outside its own state
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            in_cnt_r   <= {BW{1'b0}};
            out_cnt_r  <= {BW{1'b0}};
            wait_cnt_r <= {TW{1'b0}};
        end else begin
            if (state_r == ST_LOAD) begin
                if (accept_s) in_cnt_r <= in_cnt_r + 1'b1;
                else          in_cnt_r <= in_cnt_r;
            end else begin
                in_cnt_r <= {BW{1'b0}};
            end
            if (state_r == ST_WAIT) wait_cnt_r <= wait_cnt_r + 1'b1;
            else                    wait_cnt_r <= {TW{1'b0}};
            if (state_r == ST_UNLOAD) begin
                if (capture_s) out_cnt_r <= out_cnt_r + 1'b1;
                else           out_cnt_r <= out_cnt_r;
            end else begin
                out_cnt_r <= {BW{1'b0}};
            end
        end
    end

    // READ_OUTP follows the upcoming state so it is high exactly during UNLOAD
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            fft_read_outp <= 1'b0;
        end else begin
            fft_read_outp <= (state_nx_s == ST_UNLOAD);
        end
    end

    // Output bin register; data holds between strobes
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_re    <= {WIDTH{1'b0}};
            m_im    <= {WIDTH{1'b0}};
            m_bin   <= {BW{1'b0}};
        end else begin
            m_valid <= capture_s;
            m_last  <= last_out_s;
            if (capture_s) begin
                m_re  <= fft_datao_re;
                m_im  <= fft_datao_im;
                m_bin <= out_cnt_r;
            end else begin
                m_re  <= m_re;
                m_im  <= m_im;
                m_bin <= m_bin;
            end
        end
    end

    // Frame completion pulse, frame counter and set-dominant sticky errors
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            frame_done  <= 1'b0;
            frame_cnt   <= 16'd0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            frame_done <= (state_r == ST_DONE);
            if (state_r == ST_DONE) frame_cnt <= frame_cnt + 16'd1;
            else                    frame_cnt <= frame_cnt;
            err_timeout <= timeout_s | (err_timeout & ~err_clr);
            err_overrun <= overrun_s | (err_overrun & ~err_clr);
        end
    end

`ifdef FFT_SEQ_PEAK_EN
    // Two's complement magnitude widened by one bit so the most negative value fits
    function automatic logic [WIDTH:0] abs_ext(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] e;
        e = {v[WIDTH-1], v};
        if (v[WIDTH-1]) abs_ext = (~e) + 1'b1;
        else            abs_ext = e;
    endfunction

    logic [WIDTH:0]  mag_s;
    logic [WIDTH:0]  run_max_r;
    logic [BW-1:0]   run_bin_r;

    // L1 magnitude of the incoming bin
    always_comb begin
        mag_s = abs_ext(fft_datao_re) + abs_ext(fft_datao_im);
    end

    // Running maximum, restarted at bin 0; strict compare keeps the lowest index
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            run_max_r <= {(WIDTH+1){1'b0}};
            run_bin_r <= {BW{1'b0}};
        end else begin
            if (capture_s && ((out_cnt_r == {BW{1'b0}}) || (mag_s > run_max_r))) begin
                run_max_r <= mag_s;
                run_bin_r <= out_cnt_r;
            end else begin
                run_max_r <= run_max_r;
                run_bin_r <= run_bin_r;
            end
        end
    end

    // Publish the frame peak alongside frame_done and hold it until the next frame
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            peak_mag   <= {(WIDTH+1){1'b0}};
            peak_bin   <= {BW{1'b0}};
            peak_valid <= 1'b0;
        end else begin
            if (state_r == ST_DONE) begin
                peak_mag   <= run_max_r;
                peak_bin   <= run_bin_r;
                peak_valid <= 1'b1;
            end else begin
                peak_mag   <= peak_mag;
                peak_bin   <= peak_bin;
                peak_valid <= 1'b0;
            end
        end
    end
`endif

endmodule
